inst_mem_loader: RTL and testbench

Writer-side companion to the single-cycle R-type CPU's instruction fetch path. It accepts R-type instruction fields over a valid/ready handshake and assembles each set into a 32-bit MIPS R-format word. It writes the words sequentially into the instruction memory's write port, starting at word address 0. Benches and board-level boot logic use it to preload programs that the CPU later reads through `PC`/`Inst_code`.

---
 rtl/inst_mem_loader.sv | 147 ++++++++++++++
 tb/tb_inst_mem_loader.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/inst_mem_loader.sv
// Instruction-memory preloader: packs R-type fields into MIPS words and writes them from address 0.
// Optional macro INST_CHECK_EN drops tuples outside the CPU's supported R-type set and flags err.
module inst_mem_loader #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [5:0]        opcode,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        shamt,
  input  logic [5:0]        func,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   word_cnt,
  output logic              done,
  output logic              full,
  output logic              err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_s;
  logic [ADDR_W-1:0]   addr_r;
  logic                accept_s;
  logic                legal_s;
  logic                write_s;
  logic                last_addr_s;
  logic                start_s;
  logic [31:0]         word_s;

`ifdef INST_CHECK_EN
  function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
    logic fn_ok;
    case (fn)
      6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2B, 6'h04, 6'h00: fn_ok = 1'b1;
      default: fn_ok = 1'b0;
    endcase
    return (op == 6'h00) && fn_ok;
  endfunction

  assign legal_s = is_legal(opcode, func);
`else
  assign legal_s = 1'b1;
`endif

  assign word_s      = {opcode, rs, rt, rd, shamt, func};
  assign accept_s    = in_valid && (state_r == ST_LOAD);
  assign write_s     = accept_s && legal_s;
  assign last_addr_s = (addr_r == {ADDR_W{1'b1}});
  assign start_s     = start && (state_r != ST_LOAD);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; a dropped tuple carrying in_last still ends the session
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_s = ST_LOAD;
        else       state_s = ST_IDLE;
      end
      ST_LOAD: begin
        if (accept_s && (in_last || (write_s && last_addr_s))) state_s = ST_DONE;
        else                                                   state_s = ST_LOAD;
      end
      ST_DONE: begin
        if (start) state_s = ST_LOAD;
        else       state_s = ST_DONE;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Status outputs decoded from the state register
  always_comb begin
    in_ready = 1'b0;
    done     = 1'b0;
    case (state_r)
      ST_LOAD: in_ready = 1'b1;
      ST_DONE: done     = 1'b1;
      default: begin
        in_ready = 1'b0;
        done     = 1'b0;
      end
    endcase
  end

  // Write port, address counter and session counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_we    <= 1'b0;
      mem_addr  <= {ADDR_W{1'b0}};
      mem_wdata <= 32'h0000_0000;
      addr_r    <= {ADDR_W{1'b0}};
      word_cnt  <= {(ADDR_W+1){1'b0}};
      full      <= 1'b0;
    end else begin
      mem_we <= write_s;
      if (start_s) begin
        addr_r   <= {ADDR_W{1'b0}};
        word_cnt <= {(ADDR_W+1){1'b0}};
        full     <= 1'b0;
      end else if (write_s) begin
        mem_addr  <= addr_r;
        mem_wdata <= word_s;
        addr_r    <= addr_r + ADDR_W'(1);
        word_cnt  <= word_cnt + (ADDR_W+1)'(1);
        if (last_addr_s && !in_last) full <= 1'b1;
      end
    end
  end

`ifdef INST_CHECK_EN
  // Sticky illegal-tuple flag, cleared only by a new session
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (start_s) begin
      err <= 1'b0;
    end else if (accept_s && !legal_s) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_inst_mem_loader.sv
// Bench for inst_mem_loader (ADDR_W=2): directed scenarios plus a randomized session model.
// Expectations follow INST_CHECK_EN the same way the design is built.
module tb_inst_mem_loader;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic [5:0]    opcode = 6'h00;
  logic [4:0]    rs = 5'd0, rt = 5'd0, rd = 5'd0, shamt = 5'd0;
  logic [5:0]    func = 6'h00;
  logic          in_ready, mem_we, done, full, err;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [AW:0]   word_cnt;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [31:0] W_ADD = 32'h00221820;
  localparam logic [31:0] W_SUB = 32'h00853022;
  localparam logic [31:0] W_OR  = {6'h00, 5'd7, 5'd8, 5'd9, 5'd0, 6'h25};
  localparam logic [31:0] W_BAD = {6'h00, 5'd1, 5'd1, 5'd1, 5'd0, 6'h08};

  inst_mem_loader #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
    .func(func), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .word_cnt(word_cnt), .done(done), .full(full), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Apply one cycle of inputs at the falling edge, return just after the rising edge
  task automatic drive(input logic s, input logic v, input logic l, input logic [31:0] w);
    @(negedge clk);
    start = s; in_valid = v; in_last = l;
    {opcode, rs, rt, rd, shamt, func} = w;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if ({in_ready, mem_we, mem_addr, mem_wdata, word_cnt, done, full, err} !== '0) begin
      n_errors++; $display("FAIL reset_outputs: got we=%b addr=%h data=%h cnt=%0d done=%b full=%b err=%b rdy=%b required all 0",
        mem_we, mem_addr, mem_wdata, word_cnt, done, full, err, in_ready);
    end
    @(negedge clk); rst = 1'b0;
    drive(1'b0, 1'b1, 1'b0, W_ADD);
    n_checks++; if (mem_we !== 1'b0 || in_ready !== 1'b0) begin n_errors++; $display("FAIL idle_ignores_valid: got we=%b rdy=%b required 0 0", mem_we, in_ready); end
  endtask

  task automatic test_three_word();
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL start_ready: got %b required 1", in_ready); end
    drive(1'b0, 1'b1, 1'b0, W_ADD);
    n_checks++; if (mem_we !== 1'b1 || mem_addr !== 2'd0 || mem_wdata !== 32'h00221820 || word_cnt !== 3'd1 || done !== 1'b0) begin
      n_errors++; $display("FAIL three_w0: got we=%b addr=%0d data=%h cnt=%0d done=%b required 1 0 00221820 1 0", mem_we, mem_addr, mem_wdata, word_cnt, done); end
    drive(1'b0, 1'b1, 1'b0, W_SUB);
    n_checks++; if (mem_we !== 1'b1 || mem_addr !== 2'd1 || mem_wdata !== 32'h00853022 || word_cnt !== 3'd2) begin
      n_errors++; $display("FAIL three_w1: got we=%b addr=%0d data=%h cnt=%0d required 1 1 00853022 2", mem_we, mem_addr, mem_wdata, word_cnt); end
    drive(1'b0, 1'b1, 1'b1, W_OR);
    n_checks++; if (mem_we !== 1'b1 || mem_addr !== 2'd2 || mem_wdata !== W_OR || word_cnt !== 3'd3 || done !== 1'b1 || in_ready !== 1'b0 || full !== 1'b0) begin
      n_errors++; $display("FAIL three_w2: got we=%b addr=%0d data=%h cnt=%0d done=%b rdy=%b full=%b required 1 2 %h 3 1 0 0",
        mem_we, mem_addr, mem_wdata, word_cnt, done, in_ready, full, W_OR); end
    drive(1'b0, 1'b1, 1'b0, W_ADD);
    n_checks++; if (mem_we !== 1'b0 || done !== 1'b1 || word_cnt !== 3'd3) begin
      n_errors++; $display("FAIL three_after: got we=%b done=%b cnt=%0d required 0 1 3", mem_we, done, word_cnt); end
  endtask

  task automatic test_fill();
    logic [31:0] w;
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    n_checks++; if (done !== 1'b0 || word_cnt !== 3'd0 || in_ready !== 1'b1) begin
      n_errors++; $display("FAIL fill_start: got done=%b cnt=%0d rdy=%b required 0 0 1", done, word_cnt, in_ready); end
    for (int i = 0; i < 4; i++) begin
      w = {6'h00, 5'd1, 5'd2, 5'(i), 5'd0, 6'h20};
      drive(1'b0, 1'b1, 1'b0, w);
      n_checks++; if (mem_we !== 1'b1 || mem_addr !== AW'(i) || mem_wdata !== w || word_cnt !== 3'(i + 1)) begin
        n_errors++; $display("FAIL fill_w%0d: got we=%b addr=%0d data=%h cnt=%0d required 1 %0d %h %0d", i, mem_we, mem_addr, mem_wdata, word_cnt, i, w, i + 1); end
    end
    n_checks++; if (full !== 1'b1 || done !== 1'b1 || in_ready !== 1'b0) begin
      n_errors++; $display("FAIL fill_flags: got full=%b done=%b rdy=%b required 1 1 0", full, done, in_ready); end
    drive(1'b0, 1'b1, 1'b0, W_ADD);
    n_checks++; if (mem_we !== 1'b0 || word_cnt !== 3'd4 || full !== 1'b1) begin
      n_errors++; $display("FAIL fill_fifth: got we=%b cnt=%0d full=%b required 0 4 1", mem_we, word_cnt, full); end
  endtask

  task automatic test_illegal();
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    n_checks++; if (full !== 1'b0 || err !== 1'b0) begin n_errors++; $display("FAIL illegal_start: got full=%b err=%b required 0 0", full, err); end
    drive(1'b0, 1'b1, 1'b0, W_ADD);
    drive(1'b0, 1'b1, 1'b0, W_BAD);
`ifdef INST_CHECK_EN
    n_checks++; if (mem_we !== 1'b0 || err !== 1'b1 || word_cnt !== 3'd1) begin
      n_errors++; $display("FAIL illegal_drop: got we=%b err=%b cnt=%0d required 0 1 1", mem_we, err, word_cnt); end
    drive(1'b0, 1'b1, 1'b1, W_OR);
    n_checks++; if (mem_we !== 1'b1 || mem_addr !== 2'd1 || word_cnt !== 3'd2 || err !== 1'b1 || done !== 1'b1) begin
      n_errors++; $display("FAIL illegal_end: got we=%b addr=%0d cnt=%0d err=%b done=%b required 1 1 2 1 1", mem_we, mem_addr, word_cnt, err, done); end
`else
    n_checks++; if (mem_we !== 1'b1 || mem_addr !== 2'd1 || mem_wdata !== W_BAD || err !== 1'b0) begin
      n_errors++; $display("FAIL unchecked_w1: got we=%b addr=%0d data=%h err=%b required 1 1 %h 0", mem_we, mem_addr, mem_wdata, err, W_BAD); end
    drive(1'b0, 1'b1, 1'b1, W_OR);
    n_checks++; if (mem_we !== 1'b1 || mem_addr !== 2'd2 || word_cnt !== 3'd3 || err !== 1'b0 || done !== 1'b1) begin
      n_errors++; $display("FAIL unchecked_end: got we=%b addr=%0d cnt=%0d err=%b done=%b required 1 2 3 0 1", mem_we, mem_addr, word_cnt, err, done); end
`endif
  endtask

  task automatic test_restart();
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    drive(1'b0, 1'b1, 1'b0, W_ADD);
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    n_checks++; if (word_cnt !== 3'd1 || in_ready !== 1'b1 || mem_we !== 1'b0) begin
      n_errors++; $display("FAIL load_start_ignored: got cnt=%0d rdy=%b we=%b required 1 1 0", word_cnt, in_ready, mem_we); end
    drive(1'b0, 1'b1, 1'b0, W_SUB);
    n_checks++; if (mem_we !== 1'b1 || mem_addr !== 2'd1 || mem_wdata !== W_SUB) begin
      n_errors++; $display("FAIL restart_addr1: got we=%b addr=%0d data=%h required 1 1 %h", mem_we, mem_addr, mem_wdata, W_SUB); end
    drive(1'b0, 1'b1, 1'b1, W_OR);
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    n_checks++; if (done !== 1'b0 || word_cnt !== 3'd0 || in_ready !== 1'b1) begin
      n_errors++; $display("FAIL done_restart: got done=%b cnt=%0d rdy=%b required 0 0 1", done, word_cnt, in_ready); end
    drive(1'b0, 1'b1, 1'b0, W_ADD);
    n_checks++; if (mem_we !== 1'b1 || mem_addr !== 2'd0 || word_cnt !== 3'd1) begin
      n_errors++; $display("FAIL restart_addr0: got we=%b addr=%0d cnt=%0d required 1 0 1", mem_we, mem_addr, word_cnt); end
  endtask

  task automatic test_reset_mid();
    drive(1'b0, 1'b1, 1'b0, W_SUB);
    #2; rst = 1'b1; #1;
    n_checks++;
    if ({in_ready, mem_we, mem_addr, mem_wdata, word_cnt, done, full, err} !== '0) begin
      n_errors++; $display("FAIL reset_mid: got we=%b addr=%h data=%h cnt=%0d done=%b full=%b err=%b rdy=%b required all 0",
        mem_we, mem_addr, mem_wdata, word_cnt, done, full, err, in_ready);
    end
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, 1'b1, W_ADD);
      n_checks++; if (mem_we !== 1'b0 || in_ready !== 1'b0 || word_cnt !== 3'd0) begin
        n_errors++; $display("FAIL reset_no_write%0d: got we=%b rdy=%b cnt=%0d required 0 0 0", i, mem_we, in_ready, word_cnt); end
    end
  endtask

  // Randomized sessions against a count/flag model of the loader's contract
  task automatic test_random();
    logic [5:0]  legal_fn [9] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2B, 6'h04, 6'h00};
    logic        m_load = 1'b0, m_done = 1'b0, m_full = 1'b0, m_err = 1'b0;
    logic [2:0]  m_cnt = 3'd0;
    logic        s, v, l, ok, exp_we;
    logic [1:0]  exp_addr;
    logic [31:0] w;
    for (int c = 0; c < 600; c++) begin
      n_checks++; if (in_ready !== m_load) begin n_errors++; $display("FAIL rnd_ready c%0d: got %b required %b", c, in_ready, m_load); end
      s = m_load ? ($urandom_range(9) == 0) : ($urandom_range(2) == 0);
      v = ($urandom_range(3) != 0);
      l = ($urandom_range(4) == 0);
      w = $urandom;
      if ($urandom_range(5) != 0) begin
        w[31:26] = 6'h00;
        w[5:0]   = legal_fn[$urandom_range(8)];
      end
`ifdef INST_CHECK_EN
      ok = (w[31:26] == 6'h00) && (w[5:0] inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2B, 6'h04, 6'h00});
`else
      ok = 1'b1;
`endif
      exp_we = 1'b0; exp_addr = m_cnt[1:0];
      if (!m_load && s) begin
        m_load = 1'b1; m_cnt = 3'd0; m_done = 1'b0; m_full = 1'b0; m_err = 1'b0;
      end else if (m_load && v) begin
        if (ok) begin
          exp_we = 1'b1; m_cnt = m_cnt + 3'd1;
          if (m_cnt == 3'd4 && !l) m_full = 1'b1;
        end else begin
          m_err = 1'b1;
        end
        if (l || m_cnt == 3'd4) begin m_load = 1'b0; m_done = 1'b1; end
      end
      drive(s, v, l, w);
      n_checks++; if (mem_we !== exp_we) begin n_errors++; $display("FAIL rnd_we c%0d: got %b required %b", c, mem_we, exp_we); end
      if (exp_we) begin
        n_checks++; if (mem_addr !== exp_addr || mem_wdata !== w) begin
          n_errors++; $display("FAIL rnd_write c%0d: got addr=%0d data=%h required %0d %h", c, mem_addr, mem_wdata, exp_addr, w); end
      end
      n_checks++; if (word_cnt !== m_cnt || done !== m_done || full !== m_full || err !== m_err) begin
        n_errors++; $display("FAIL rnd_status c%0d: got cnt=%0d done=%b full=%b err=%b required %0d %b %b %b",
          c, word_cnt, done, full, err, m_cnt, m_done, m_full, m_err); end
    end
  endtask

  initial begin
    test_reset();
    test_three_word();
    test_fill();
    test_illegal();
    test_restart();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
